// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller with sub-word read-modify-write
//
// Purpose: accepts one load or store at a time and drives a word-organised
// data memory. Handles byte/halfword/word sizes, sign or zero extension on
// loads, and merges sub-word stores into the existing memory word.
//
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Req                 request, sampled only while idle
//   ReqWe               1 = store, 0 = load
//   ReqSize             00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   ReqSigned           load extension: 1 = sign, 0 = zero
//   ReqAddr, ReqWdata   byte address and store data (sub-word in low bits)
//   Busy                high whenever not idle
//   Done, Misalign      one-cycle completion pulse and its fault flag
//   Rdata               last successful load result
//   MemAddr, MemDin     word address and write data to memory
//   MemWe               memory write enable
//   MemDout             combinational memory read data for MemAddr
module lsu_ctrl (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req,
    input  logic        ReqWe,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWdata,
    output logic        Busy,
    output logic        Done,
    output logic        Misalign,
    output logic [31:0] Rdata,
    output logic [31:0] MemAddr,
    output logic [31:0] MemDin,
    output logic        MemWe,
    input  logic [31:0] MemDout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] merge_q;

    logic        req_misalign;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        req_misalign = 1'b0;
        case (ReqSize)
            2'b00:   req_misalign = 1'b0;
            2'b01:   req_misalign = ReqAddr[0];
            2'b10:   req_misalign = (ReqAddr[1:0] != 2'b00);
            default: req_misalign = 1'b1;
        endcase
    end

    // Little-endian lanes: a halfword lane is always 16-bit aligned once the
    // request is accepted, so the byte offset doubles as the half offset.
    assign lane_shift = {addr_q[1:0], 3'b000};
    assign lane_mask  = (size_q == 2'b00) ? (32'h0000_00FF << lane_shift)
                                          : (32'h0000_FFFF << lane_shift);
    assign lane_data  = MemDout >> lane_shift;

    always_comb begin
        load_data = MemDout;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
            default: load_data = MemDout;
        endcase
    end

    assign merged = (MemDout & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            merge_q  <= 32'h0;
            Rdata    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        we_q     <= ReqWe;
                        size_q   <= ReqSize;
                        signed_q <= ReqSigned;
                        addr_q   <= ReqAddr;
                        wdata_q  <= ReqWdata;
                        fault_q  <= req_misalign;
                        if (req_misalign)
                            state <= DONE;
                        else if (!ReqWe)
                            state <= LOAD;
                        else if (ReqSize == 2'b10)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                LOAD: begin
                    Rdata <= load_data;
                    state <= DONE;
                end
                READ: begin
                    merge_q <= merged;
                    state   <= WRITE;
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from state so an asynchronous reset removes MemWe
    // immediately, even in the middle of the write cycle.
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);
    assign Misalign = (state == DONE) && fault_q;
    assign MemWe    = (state == WRITE);
    assign MemAddr  = (state == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign MemDin   = (state != WRITE) ? 32'h0
                    : ((size_q == 2'b10) ? wdata_q : merge_q);

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req;
    logic        ReqWe;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWdata;
    logic        Busy;
    logic        Done;
    logic        Misalign;
    logic [31:0] Rdata;
    logic [31:0] MemAddr;
    logic [31:0] MemDin;
    logic        MemWe;
    logic [31:0] MemDout;

    logic [31:0] mem [0:15];
    logic        mem_init;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    lsu_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqWe(ReqWe), .ReqSize(ReqSize),
        .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWdata(ReqWdata),
        .Busy(Busy), .Done(Done), .Misalign(Misalign), .Rdata(Rdata),
        .MemAddr(MemAddr), .MemDin(MemDin), .MemWe(MemWe), .MemDout(MemDout)
    );

    assign MemDout = mem[MemAddr[5:2]];

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h0000_0003;
            mem[2] <= 32'h0000_0004;
        end else if (MemWe) begin
            mem[MemAddr[5:2]] <= MemDin;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        fault;
        logic [31:0] rdata;
        int          wr;
        logic [31:0] din;
    } vec_t;

    vec_t vt [17];

    // One request: accept edge, then count cycles until Done (bounded).
    task automatic run_req(input vec_t v, output int lat, output logic mis,
                           output int wr, output logic [31:0] din, output int busy_low);
        lat = 0; mis = 1'b0; wr = 0; din = 32'h0; busy_low = 0;
        @(negedge Clk);
        ReqWe = v.we; ReqSize = v.size; ReqSigned = v.sgn;
        ReqAddr = v.addr; ReqWdata = v.wdata; Req = 1'b1;
        @(posedge Clk);
        #1 Req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (!Busy) busy_low++;
            if (MemWe) begin
                wr++;
                din = MemDin;
            end
            if (Done) begin
                lat = c;
                mis = Misalign;
                break;
            end
        end
    endtask

    initial begin
        int lat, wr, busy_low;
        logic mis;
        logic [31:0] din;
        int done_cyc [$];
        int we_cyc [$];
        logic [31:0] b2b_din;
        int idle_after;

        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,         2, 1'b0, 32'h0000_0003, 0, 32'h0};
        vt[1]  = '{1'b1, 2'b00, 1'b0, 32'h9, 32'hAAAA_AA80, 3, 1'b0, 32'h0000_0003, 1, 32'h0000_8004};
        vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h9, 32'h0,         2, 1'b0, 32'hFFFF_FF80, 0, 32'h0};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h9, 32'h0,         2, 1'b0, 32'h0000_0080, 0, 32'h0};
        vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h8, 32'h0,         2, 1'b0, 32'hFFFF_8004, 0, 32'h0};
        vt[5]  = '{1'b0, 2'b01, 1'b0, 32'h8, 32'h0,         2, 1'b0, 32'h0000_8004, 0, 32'h0};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h3, 32'h0,         1, 1'b1, 32'h0000_8004, 0, 32'h0};
        vt[7]  = '{1'b1, 2'b10, 1'b0, 32'h6, 32'h1111_1111, 1, 1'b1, 32'h0000_8004, 0, 32'h0};
        vt[8]  = '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0,         1, 1'b1, 32'h0000_8004, 0, 32'h0};
        vt[9]  = '{1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_8004, 1, 32'hDEAD_BEEF};
        vt[10] = '{1'b0, 2'b10, 1'b0, 32'hC, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 0, 32'h0};
        vt[11] = '{1'b1, 2'b01, 1'b0, 32'hE, 32'hFFFF_1234, 3, 1'b0, 32'hDEAD_BEEF, 1, 32'h1234_BEEF};
        vt[12] = '{1'b0, 2'b01, 1'b1, 32'hE, 32'h0,         2, 1'b0, 32'h0000_1234, 0, 32'h0};
        vt[13] = '{1'b0, 2'b00, 1'b1, 32'hC, 32'h0,         2, 1'b0, 32'hFFFF_FFEF, 0, 32'h0};
        vt[14] = '{1'b0, 2'b00, 1'b0, 32'hF, 32'h0,         2, 1'b0, 32'h0000_0012, 0, 32'h0};
        vt[15] = '{1'b1, 2'b00, 1'b1, 32'hD, 32'h0000_0055, 3, 1'b0, 32'h0000_0012, 1, 32'h1234_55EF};
        vt[16] = '{1'b0, 2'b10, 1'b0, 32'hC, 32'h0,         2, 1'b0, 32'h1234_55EF, 0, 32'h0};

        // Reset with Req asserted
        Rst_n = 1'b0; mem_init = 1'b1; Req = 1'b1; ReqWe = 1'b1; ReqSize = 2'b10;
        ReqSigned = 1'b0; ReqAddr = 32'h4; ReqWdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check("reset_outputs", {29'h0, Busy, Done, Misalign}, 32'h0);
            check("reset_memwe_addr", {31'h0, MemWe} | MemAddr, 32'h0);
            check("reset_din_rdata", MemDin | Rdata, 32'h0);
        end
        Req = 1'b0; Rst_n = 1'b1; mem_init = 1'b0;
        @(negedge Clk);
        check("idle_after_reset", {31'h0, Busy}, 32'h0);
        check("mem_word1_init", mem[1], 32'h0000_0003);

        for (int i = 0; i < 17; i++) begin
            run_req(vt[i], lat, mis, wr, din, busy_low);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            check($sformatf("v%0d_misalign", i), {31'h0, mis}, {31'h0, vt[i].fault});
            check($sformatf("v%0d_writes", i), wr, vt[i].wr);
            if (vt[i].wr != 0) check($sformatf("v%0d_memdin", i), din, vt[i].din);
            check($sformatf("v%0d_busy_until_done", i), busy_low, 0);
            check($sformatf("v%0d_rdata", i), Rdata, vt[i].rdata);
            @(negedge Clk);
            check($sformatf("v%0d_idle_after_done", i), {31'h0, Busy}, 32'h0);
        end

        // Reset during the READ cycle of a halfword store
        @(negedge Clk);
        ReqWe = 1'b1; ReqSize = 2'b01; ReqSigned = 1'b0; ReqAddr = 32'h4;
        ReqWdata = 32'h0000_BEEF; Req = 1'b1;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(negedge Clk);
        check("midrst_busy_in_read", {31'h0, Busy}, 32'h1);
        Rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, Busy}, 32'h0);
        check("midrst_memwe", {31'h0, MemWe}, 32'h0);
        check("midrst_done", {31'h0, Done}, 32'h0);
        wr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (MemWe || Done) wr++;
        end
        Rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (MemWe || Done || Busy) wr++;
        end
        check("midrst_no_activity", wr, 0);
        check("midrst_word1", mem[1], 32'h0000_0003);
        check("midrst_rdata", Rdata, 32'h0);

        // Req held across three mixed requests, inputs changing while busy
        @(negedge Clk);
        ReqWe = 1'b0; ReqSize = 2'b10; ReqSigned = 1'b0; ReqAddr = 32'h4;
        ReqWdata = 32'h0; Req = 1'b1;
        @(posedge Clk);
        b2b_din = 32'h0;
        idle_after = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (Done) done_cyc.push_back(c);
            if (Done && Misalign && c != 7) bad++;
            if (MemWe) begin
                we_cyc.push_back(c);
                b2b_din = MemDin;
            end
            if (c == 1) begin
                Req = 1'b0;
                ReqWe = 1'b1; ReqSize = 2'b10; ReqAddr = 32'h10; ReqWdata = 32'hCAFE_F00D;
            end
            if (c == 2) Req = 1'b1;
            if (c == 4) begin
                ReqWe = 1'b0; ReqSize = 2'b10; ReqAddr = 32'h2; ReqWdata = 32'h0;
            end
            if (c == 7) begin
                check("b2b_c_misalign", {31'h0, Misalign}, 32'h1);
                Req = 1'b0;
            end
            if (c == 8 && !Busy) idle_after = 1;
        end
        check("b2b_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_done0", done_cyc[0], 2);
            check("b2b_done1", done_cyc[1], 5);
            check("b2b_done2", done_cyc[2], 7);
        end
        check("b2b_we_count", we_cyc.size(), 1);
        if (we_cyc.size() == 1) check("b2b_we_cycle", we_cyc[0], 4);
        check("b2b_memdin", b2b_din, 32'hCAFE_F00D);
        check("b2b_mem4", mem[4], 32'hCAFE_F00D);
        check("b2b_rdata", Rdata, 32'h0000_0003);
        check("b2b_idle_end", idle_after, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
